acc_bank: RTL
=============

ACC_BANK -- requirements
Module: acc_bank

Interface
REQ-001 Parameter WIDTH, default 10, data width of each accumulator and of din/dout.
REQ-002 Parameter NUM_ACC, default 4, number of accumulators (power of two, >=2).
REQ-003 Parameter SAT, default 0, 0 = wrap-around arithmetic, 1 = signed saturating arithmetic.
REQ-004 Derived constant SEL_W = log2(NUM_ACC), default 2.
REQ-005 One clock; reset is synchronous and active-high; ports clk and rst.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 op_valid  input  1  qualifies op/sel/din this cycle.
REQ-009 op  input  3  opcode: 000 NOP, 001 LOAD, 010 ADD, 011 SUB, 100 CLR; 101-111 reserved.
REQ-010 sel  input  SEL_W  target accumulator for op.
REQ-011 din  input  WIDTH  operand for LOAD/ADD/SUB.
REQ-012 rd_en  input  1  request readout of accumulator rd_sel.
REQ-013 rd_sel  input  SEL_W  accumulator to read.
REQ-014 clear_out  input  1  zero the output register.
REQ-015 dout  output  WIDTH  registered readout data.
REQ-016 dout_valid  output  1  dout holds data from a read issued the previous cycle.
REQ-017 flag_z, flag_c, flag_v  output  1 each  zero, carry/borrow, signed overflow of last arithmetic/load op.

Function
REQ-018 Ops shall take effect on the rising edge after op_valid=1; accumulator updated value visible to reads issued one cycle later.
REQ-019 LOAD shall write din to acc[sel]; ADD shall write acc[sel]+din; SUB shall write acc[sel]-din; CLR shall write 0 to acc[sel].
REQ-020 Reserved opcodes and op_valid=0 shall change no accumulator and no flag.
REQ-021 Arithmetic shall be WIDTH bits; SAT=0: result is low WIDTH bits (wrap); SAT=1: on signed overflow result clamps to 2^(WIDTH-1)-1 (positive) or -2^(WIDTH-1) (negative).
REQ-022 flag_c shall equal unsigned carry-out for ADD and borrow (acc<din unsigned) for SUB; 0 for LOAD/CLR.
REQ-023 flag_v shall be 1 on signed overflow of ADD/SUB regardless of SAT; 0 for LOAD/CLR.
REQ-024 flag_z shall be 1 when the value written to acc[sel] is 0; flags update only on valid LOAD/ADD/SUB/CLR and otherwise hold.
REQ-025 rd_en=1 shall register acc[rd_sel] into dout with dout_valid=1 on the next edge; latency exactly 1 cycle.
REQ-026 Read and op in the same cycle on the same accumulator shall return the pre-update value (read-before-write).
REQ-027 rd_en=0 shall set dout_valid=0 and hold dout.
REQ-028 clear_out=1 shall force dout=0 and dout_valid=0 at the next edge, overriding a same-cycle rd_en; accumulators unaffected.
REQ-029 Back-to-back ops on the same accumulator every cycle shall chain without stall (each op sees the previous result).

Reset
REQ-030 rst=1 at a clock edge shall set all accumulators, dout, dout_valid and all flags to 0, overriding every other input.
REQ-031 An op or read presented in the same cycle as rst shall be discarded; no pending effect after rst deasserts.

Structure
REQ-032 Shared package acc_bank_pkg shall hold the opcode constants (OP_NOP, OP_LOAD, OP_ADD, OP_SUB, OP_CLR) and the op typedef.
REQ-033 Combinational sub-module acc_alu shall compute result, carry, overflow and saturation for one accumulator/operand pair; acc_bank instantiates one.

Verification (WIDTH=10, NUM_ACC=4)
REQ-034 LOAD acc1=0x155, next cycle rd_en rd_sel=1 -> dout=0x155, dout_valid=1 one cycle later; flag_z=0.
REQ-035 SAT=0: acc0=0x1FF, ADD 0x001 -> acc0=0x200, flag_v=1, flag_c=0; SAT=1 same stimulus -> acc0=0x1FF, flag_v=1.
REQ-036 acc2=0x000, SUB 0x001 -> acc2=0x3FF, flag_c=1, flag_v=0, flag_z=0; then CLR acc2 -> flag_z=1, flag_c=0.
REQ-037 Same cycle ADD 0x010 to acc3 (=0x020) and rd_en rd_sel=3 -> dout=0x020; read next cycle -> 0x030.
REQ-038 rd_en and clear_out same cycle -> dout=0x000, dout_valid=0; accumulators unchanged on subsequent reads.
REQ-039 rst asserted mid-sequence with op_valid=1 LOAD 0x2AA -> all accs, dout, flags 0 after edge; read of target returns 0x000.

Source files
------------

// File: rtl/acc_bank_pkg.sv
// acc_bank_pkg: opcodes and shared helpers for the accumulator bank
package acc_bank_pkg;
  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_CLR  = 3'b100
  } op_e;
  function automatic logic op_writes(input logic [2:0] op);
    return op == OP_LOAD || op == OP_ADD || op == OP_SUB || op == OP_CLR;
  endfunction
endpackage

// File: rtl/acc_alu.sv
// acc_alu: result, carry/borrow, signed overflow and optional saturation for one op
module acc_alu
  import acc_bank_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter bit SAT   = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             c,
  output logic             v,
  output logic             z
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic             add_v;
  logic             sub_v;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] lim;
  assign sum   = {1'b0, a} + {1'b0, b};
  assign dif   = {1'b0, a} - {1'b0, b};
  assign add_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
  // an overflow always pushes past the bound on the side of a's sign
  assign lim   = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  always_comb begin
    raw = op == OP_ADD ? sum[WIDTH-1:0] : op == OP_SUB ? dif[WIDTH-1:0] : op == OP_LOAD ? b : '0;
    c   = op == OP_ADD ? sum[WIDTH] : op == OP_SUB ? dif[WIDTH] : 1'b0;
    v   = op == OP_ADD ? add_v : op == OP_SUB ? sub_v : 1'b0;
    res = (SAT && v) ? lim : raw;
    z   = res == '0;
  end
endmodule

// File: rtl/acc_bank.sv
// acc_bank: bank of NUM_ACC accumulators with flags and a one-cycle registered readout
module acc_bank
  import acc_bank_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int NUM_ACC = 4,
  parameter bit SAT     = 1'b0,
  localparam int SEL_W  = $clog2(NUM_ACC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  input  logic [SEL_W-1:0] rd_sel,
  input  logic             clear_out,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);
  logic [WIDTH-1:0] acc [NUM_ACC];
  logic [WIDTH-1:0] res;
  logic             c;
  logic             v;
  logic             z;
  acc_alu #(.WIDTH(WIDTH), .SAT(SAT)) u_alu (
    .a  (acc[sel]),
    .b  (din),
    .op (op),
    .res(res),
    .c  (c),
    .v  (v),
    .z  (z)
  );
  // readout samples acc before this edge's write, giving read-before-write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
    end else begin
      if (op_valid && op_writes(op)) begin
        acc[sel] <= res;
        flag_z   <= z;
        flag_c   <= c;
        flag_v   <= v;
      end
      dout       <= clear_out ? '0 : rd_en ? acc[rd_sel] : dout;
      dout_valid <= rd_en && !clear_out;
    end
  end
endmodule
